// File: rtl/svc_rv_div_seq.sv
// Iterative radix-2 restoring divider for RISC-V DIV/DIVU/REM/REMU, stalling the pipeline while it runs.
// Optional single-entry result cache enabled by defining SVC_RV_DIV_CACHE_EN.
module svc_rv_div_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            flush,
    output logic            op_active_ex,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [1:0]      dbg_state
);

    localparam int CW = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   count;
    logic [XLEN-1:0] dvd;      // dividend shifts out, quotient shifts in
    logic [XLEN-1:0] rem;
    logic [XLEN-1:0] dvsr;
    logic            is_rem, neg_q, neg_r;

    logic            accept, signed_in, rem_in, div_zero, ovf, special, last;
    logic [XLEN-1:0] abs1, abs2, special_res;
    logic [XLEN:0]   rem_shift;
    logic [XLEN-1:0] sub, rem_nxt, quo_nxt, q_fix, r_fix;
    logic            q_bit;
    logic            hit;
    logic [XLEN-1:0] hit_res;

    always_comb begin
        signed_in   = ~op[0];
        rem_in      = op[1];
        accept      = !rst && state == S_IDLE && start && !flush;
        div_zero    = rs2 == '0;
        ovf         = signed_in && rs1 == MIN_NEG && rs2 == '1;
        special     = div_zero || ovf;
        abs1        = (signed_in && rs1[XLEN-1]) ? -rs1 : rs1;
        abs2        = (signed_in && rs2[XLEN-1]) ? -rs2 : rs2;
        if (div_zero)
            special_res = rem_in ? rs1 : '1;
        else
            special_res = rem_in ? '0 : rs1;

        // One restoring step; the true difference always fits in XLEN bits when taken.
        rem_shift   = {rem, dvd[XLEN-1]};
        q_bit       = rem_shift >= {1'b0, dvsr};
        sub         = rem_shift[XLEN-1:0] - dvsr;
        rem_nxt     = q_bit ? sub : rem_shift[XLEN-1:0];
        quo_nxt     = {dvd[XLEN-2:0], q_bit};
        q_fix       = neg_q ? -quo_nxt : quo_nxt;
        r_fix       = neg_r ? -rem_nxt : rem_nxt;
        last        = state == S_CALC && count == CW'(1);
        op_active_ex = !rst && ((state == S_IDLE && start && !flush) || state == S_CALC);
        dbg_state   = state;
    end

`ifdef SVC_RV_DIV_CACHE_EN
    logic            c_valid, c_signed, l_signed;
    logic [XLEN-1:0] c_rs1, c_rs2, c_q, c_r, l_rs1, l_rs2;

    always_comb begin
        hit     = c_valid && c_rs1 == rs1 && c_rs2 == rs2 && c_signed == signed_in && !special;
        hit_res = rem_in ? c_r : c_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            c_valid  <= 1'b0;
            c_signed <= 1'b0;
            l_signed <= 1'b0;
            c_rs1    <= '0;
            c_rs2    <= '0;
            c_q      <= '0;
            c_r      <= '0;
            l_rs1    <= '0;
            l_rs2    <= '0;
        end else begin
            if (accept) begin
                l_rs1    <= rs1;
                l_rs2    <= rs2;
                l_signed <= signed_in;
            end
            if (state == S_CALC && flush) begin
                c_valid <= 1'b0;
            end else if (last) begin
                c_valid  <= 1'b1;
                c_rs1    <= l_rs1;
                c_rs2    <= l_rs2;
                c_signed <= l_signed;
                c_q      <= q_fix;
                c_r      <= r_fix;
            end
        end
    end
`else
    always_comb begin
        hit     = 1'b0;
        hit_res = '0;
    end
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept) state_nxt = (special || hit) ? S_DONE : S_CALC;
            S_CALC: if (last) state_nxt = S_DONE;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (flush) state_nxt = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            done   <= 1'b0;
            result <= '0;
            count  <= '0;
            dvd    <= '0;
            rem    <= '0;
            dvsr   <= '0;
            is_rem <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= state_nxt == S_DONE;
            if (accept) begin
                dvd    <= abs1;
                dvsr   <= abs2;
                rem    <= '0;
                count  <= CW'(XLEN);
                is_rem <= rem_in;
                neg_q  <= signed_in && (rs1[XLEN-1] ^ rs2[XLEN-1]);
                neg_r  <= signed_in && rs1[XLEN-1];
                if (special)
                    result <= special_res;
                else if (hit)
                    result <= hit_res;
            end else if (state == S_CALC && !flush) begin
                dvd   <= quo_nxt;
                rem   <= rem_nxt;
                count <= count - CW'(1);
                if (last) result <= is_rem ? r_fix : q_fix;
            end
        end
    end

endmodule
